// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating counters,
// combinational IF-stage lookup, EX-stage training and mispredict redirect.
module branch_predict_unit #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  input  logic              flush_all,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    if (up)
      return (&c) ? c : c + CTR_W'(1);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, mispredict;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup: reads the array as it stands before this cycle's update (no bypass)
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + ADDR_W'(4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    mispredict = 1'b0;
    if (ex_is_branch)
      mispredict = ex_taken ? (!ex_pred_taken || (ex_pred_target != ex_target)) : ex_pred_taken;
    else
      mispredict = ex_pred_taken;
  end

  assign redirect    = ex_valid && mispredict;
  assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + ADDR_W'(4);

  // Training and performance counters; flush_all overrides any valid-bit write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      if (ex_valid && ex_is_branch) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ctr_step(ctr_q[ex_idx], ex_taken);
          if (ex_taken)
            tgt_q[ex_idx] <= ex_target;
        end else if (ex_taken) begin
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
          tgt_q[ex_idx]   <= ex_target;
          ctr_q[ex_idx]   <= CTR_WEAK;
        end
      end else if (ex_valid && ex_hit) begin
        valid_q[ex_idx] <= 1'b0;
      end
      if (flush_all)
        valid_q <= '0;
      if (ex_valid && ex_is_branch)
        branch_cnt <= cnt_sat_inc(branch_cnt);
      if (redirect)
        miss_cnt <= cnt_sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus randomized traffic,
// checked against a table-based model of the predictor's rules.
module tb_branch_predict_unit;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_is_branch;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              flush_all;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  always #5 clock = ~clock;

  branch_predict_unit #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush_all(flush_all), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one record per BTB slot, counters as plain integers
  bit          mv   [ENTRIES];
  logic [31:0] mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  int          mctr [ENTRIES];
  int          mb, mm;

  logic [31:0] tpool [4] = '{32'h0000_0200, 32'h0000_0400, 32'h0000_1000, 32'h0000_0008};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 0;
    end
    mb = 0; mm = 0;
  endtask

  task automatic predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    bit hit;
    i   = int'((pc / 4) % ENTRIES);
    hit = mv[i] && (mtag[i] == pc / (4 * ENTRIES));
    t   = hit && (mctr[i] >= 2 ** (CTR_W - 1));
    tg  = t ? mtgt[i] : pc + 32'd4;
  endtask

  function automatic bit exp_redirect();
    if (!ex_valid) return 1'b0;
    if (ex_is_branch && ex_taken) return !ex_pred_taken || (ex_pred_target != ex_target);
    return ex_pred_taken;
  endfunction

  task automatic model_update(input bit redir);
    int i;
    bit hit;
    if (ex_valid) begin
      i   = int'((ex_pc / 4) % ENTRIES);
      hit = mv[i] && (mtag[i] == ex_pc / (4 * ENTRIES));
      if (ex_is_branch) begin
        if (hit) begin
          if (ex_taken) begin
            if (mctr[i] < 2 ** CTR_W - 1) mctr[i]++;
            mtgt[i] = ex_target;
          end else if (mctr[i] > 0) begin
            mctr[i]--;
          end
        end else if (ex_taken) begin
          mv[i] = 1'b1; mtag[i] = ex_pc / (4 * ENTRIES); mtgt[i] = ex_target;
          mctr[i] = 2 ** (CTR_W - 1);
        end
        if (mb < 2 ** CNT_W - 1) mb++;
      end else if (hit) begin
        mv[i] = 1'b0;
      end
    end
    if (redir && mm < 2 ** CNT_W - 1) mm++;
    if (flush_all)
      for (int k = 0; k < ENTRIES; k++) mv[k] = 1'b0;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  // One clock: check lookup/redirect before the edge, counters after it; ends on a negedge
  task automatic cycle(input string tag);
    logic t;
    logic [31:0] tg;
    bit r;
    #1;
    predict(if_pc, t, tg);
    r = exp_redirect();
    check({tag, ":pred_taken"}, {31'd0, pred_taken}, {31'd0, t});
    check({tag, ":pred_target"}, pred_target, tg);
    check({tag, ":redirect"}, {31'd0, redirect}, {31'd0, r});
    if (ex_valid)
      check({tag, ":redirect_pc"}, redirect_pc,
            (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4);
    @(posedge clock);
    model_update(r);
    #1;
    check({tag, ":branch_cnt"}, {28'd0, branch_cnt}, mb);
    check({tag, ":miss_cnt"}, {28'd0, miss_cnt}, mm);
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(15) == 0) return 32'hFFFF_FFFC;
    return 32'h100 + 32'($urandom_range(2)) * 64 + 32'($urandom_range(3)) * 4;
  endfunction

  initial begin
    logic t;
    logic [31:0] tg, pc;
    int b0;
    reset = 1'b0; flush_all = 1'b0; if_pc = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check("reset:pred_taken", {31'd0, pred_taken}, 0);
    check("reset:pred_target", pred_target, 32'h104);
    check("reset:branch_cnt", {28'd0, branch_cnt}, 0);
    check("reset:miss_cnt", {28'd0, miss_cnt}, 0);
    check("reset:redirect", {31'd0, redirect}, 0);
    @(negedge clock);
    reset = 1'b1;

    // Taken branch first seen: redirect and allocate weakly-taken
    set_ex(1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
    #1;
    check("alloc:redirect", {31'd0, redirect}, 1);
    check("alloc:redirect_pc", redirect_pc, 32'h200);
    cycle("alloc");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("alloc_after:pred_taken", {31'd0, pred_taken}, 1);
    check("alloc_after:pred_target", pred_target, 32'h200);
    check("alloc_after:miss_cnt", {28'd0, miss_cnt}, 1);
    cycle("idle1");

    // Two not-taken resolutions walk the counter down to strongly not-taken
    set_ex(1, 32'h100, 1, 0, 32'h0, 1, 32'h200);
    #1;
    check("nt1:redirect", {31'd0, redirect}, 1);
    check("nt1:redirect_pc", redirect_pc, 32'h104);
    cycle("nt1");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("nt1_after:pred_taken", {31'd0, pred_taken}, 0);
    check("nt1_after:pred_target", pred_target, 32'h104);
    set_ex(1, 32'h100, 1, 0, 32'h0, 0, 32'h104);
    cycle("nt2");
    set_ex(1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
    cycle("retrain1");
    cycle("retrain2");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("retrain:pred_taken", {31'd0, pred_taken}, 1);

    // Non-branch predicted taken: different tag leaves entry, matching tag removes it
    set_ex(1, 32'h140, 0, 0, 32'h0, 1, 32'h200);
    #1;
    check("alias140:redirect", {31'd0, redirect}, 1);
    check("alias140:redirect_pc", redirect_pc, 32'h144);
    cycle("alias140");
    set_ex(1, 32'h100, 0, 0, 32'h0, 1, 32'h200);
    cycle("alias100");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("alias_after:pred_taken", {31'd0, pred_taken}, 0);

    // flush_all together with an allocation
    b0 = mb;
    if_pc = 32'h300;
    set_ex(1, 32'h300, 1, 1, 32'h380, 0, 32'h304);
    flush_all = 1'b1;
    cycle("flush");
    flush_all = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("flush_after:pred_taken", {31'd0, pred_taken}, 0);
    check("flush_after:pred_target", pred_target, 32'h304);
    check("flush_after:branch_cnt", {28'd0, branch_cnt}, b0 + 1);
    cycle("idle2");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if_pc = pick_pc();
      pc = pick_pc();
      predict(pc, t, tg);
      set_ex($urandom_range(7) != 0, pc, $urandom_range(3) != 0, $urandom_range(1) == 1,
             tpool[$urandom_range(3)], t, tg);
      if ($urandom_range(1) == 0) begin
        ex_pred_taken = $urandom_range(1) == 1;
        ex_pred_target = tpool[$urandom_range(3)];
      end
      flush_all = $urandom_range(31) == 0;
      cycle("rand");
    end
    flush_all = 1'b0;

    // Fresh reset, then drive the miss counter into saturation
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      set_ex(1, 32'h500, 0, 0, 32'h0, 1, 32'h600);
      cycle("sat");
    end
    check("sat:miss_cnt", {28'd0, miss_cnt}, 15);

    // Train an entry, then drop reset asynchronously in mid-cycle
    if_pc = 32'h600;
    set_ex(1, 32'h600, 1, 1, 32'h700, 0, 32'h604);
    cycle("train600");
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst:pred_taken", {31'd0, pred_taken}, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst:pred_taken", {31'd0, pred_taken}, 0);
    check("mid_rst:pred_target", pred_target, 32'h604);
    check("mid_rst:branch_cnt", {28'd0, branch_cnt}, 0);
    check("mid_rst:miss_cnt", {28'd0, miss_cnt}, 0);
    check("mid_rst:redirect", {31'd0, redirect}, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
